// File: rtl/spi_target_rx.sv
// SPI target receiver (mode 0, MSB first).
// SCK, MOSI and CS_N are oversampled in the i_clk domain. Received bits are
// deserialized into WORD-bit words, and a per-word reply is shifted out on MISO.
// Each completed word is announced with a one-cycle o_valid strobe.
module spi_target_rx #(
    parameter int WORD        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_sck,
    input  logic            i_mosi,
    input  logic            i_cs_n,
    output logic            o_miso,
    input  logic [WORD-1:0] i_tx_data,
    output logic            o_tx_load,
    output logic [WORD-1:0] o_data,
    output logic            o_valid,
    output logic            o_first,
    output logic            o_abort,
    output logic            o_busy
);

    localparam int                CNT_W    = $clog2(WORD);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD - 1);
    // Cycles after reset release before the edge detectors are trusted. The
    // synchronizer chains start from their preset values, so a CS that is
    // already low would otherwise look like a fresh falling edge.
    localparam int                SETTLE   = SYNC_STAGES + 1;
    localparam logic [2:0]        SETTLE_V = 3'(SETTLE);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_n_prev_q, cs_n_prev_d;
    logic [2:0]             settle_q, settle_d;

    logic sck_s;
    logic mosi_s;
    logic cs_n_s;
    logic edge_en;
    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cs_n_s  = cs_n_sync_q[SYNC_STAGES-1];
    assign edge_en = (settle_q == SETTLE_V);

    // MOSI shares the exact path depth of SCK, so it is valid on sck_rise.
    assign sck_rise = edge_en &  sck_s  & ~sck_prev_q;
    assign sck_fall = edge_en & ~sck_s  &  sck_prev_q;
    assign cs_fall  = edge_en & ~cs_n_s &  cs_n_prev_q;
    assign cs_rise  = edge_en &  cs_n_s & ~cs_n_prev_q;

    // Next values for the synchronizer chains, edge flops and settle counter.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
        cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], i_cs_n};
        sck_prev_d  = sck_s;
        cs_n_prev_d = cs_n_s;
        settle_d    = edge_en ? settle_q : settle_q + 3'd1;
    end

    // Synchronizer registers; idle-bus values are preset during reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_n_sync_q <= '1;
            sck_prev_q  <= 1'b0;
            cs_n_prev_q <= 1'b1;
            settle_q    <= 3'd0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_n_sync_q <= cs_n_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_n_prev_q <= cs_n_prev_d;
            settle_q    <= settle_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, deserializer and reply shifter
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD-1:0]   rx_shift_q, rx_shift_d;
    logic [WORD-1:0]   tx_shift_q, tx_shift_d;
    logic              first_flag_q, first_flag_d;
    logic [WORD-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              abort_q, abort_d;
    logic              tx_load;
    logic              busy;
    logic [WORD-1:0]   rx_word;

    // Shift register contents including the bit arriving on this SCK rise.
    assign rx_word = {rx_shift_q[WORD-2:0], mosi_s};

    // Next-state logic: frame start/stop, bit reception and reply shifting.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        first_flag_d = first_flag_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        first_d      = 1'b0;
        abort_d      = 1'b0;
        tx_load      = 1'b0;
        busy         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // SCK activity is ignored until CS falls.
                if (cs_fall) begin
                    state_d      = ST_ACTIVE;
                    bit_cnt_d    = '0;
                    rx_shift_d   = '0;
                    first_flag_d = 1'b1;
                    tx_load      = 1'b1;
                    tx_shift_d   = i_tx_data;
                    busy         = 1'b1;
                end
            end

            ST_ACTIVE: begin
                busy = ~cs_rise;
                if (sck_rise) begin
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d       = rx_word;
                        valid_d      = 1'b1;
                        first_d      = first_flag_q;
                        first_flag_d = 1'b0;
                        bit_cnt_d    = '0;
                        tx_load      = 1'b1;
                        tx_shift_d   = i_tx_data;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall && (bit_cnt_q != '0)) begin
                    // With bit_cnt at zero the freshly loaded MSB is already
                    // on the line, so that fall must not shift.
                    tx_shift_d = {tx_shift_q[WORD-2:0], 1'b0};
                end

                // A word finishing on the same cycle as CS rising counts as
                // complete; only bits left over after that are an abort.
                if (cs_rise) begin
                    state_d    = ST_IDLE;
                    abort_d    = (bit_cnt_d != '0);
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            first_flag_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            first_flag_q <= first_flag_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            abort_q      <= abort_d;
        end
    end

    assign o_miso    = (state_q == ST_ACTIVE) & tx_shift_q[WORD-1];
    assign o_tx_load = tx_load;
    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_first   = first_q;
    assign o_abort   = abort_q;
    assign o_busy    = busy;

endmodule

// File: tb/tb_spi_target_rx.sv
// Testbench for spi_target_rx: an SPI host model drives frames with
// asynchronous timing, and a monitor collects DUT strobes. Expected values
// come from the byte-level view of each frame (words sent, replies queued).
module tb_spi_target_rx;

    localparam int WORD = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sck = 1'b0;
    logic            mosi = 1'b0;
    logic            cs_n = 1'b1;
    logic            miso;
    logic [WORD-1:0] tx_data = '0;
    logic            tx_load;
    logic [WORD-1:0] data;
    logic            valid;
    logic            first;
    logic            abort;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic [7:0] obs_data[$];
    logic       obs_first[$];
    int         abort_cnt = 0;
    int         load_cnt  = 0;
    int         tx_idx    = 0;

    // Host-side frame description and capture
    logic [7:0] tx_words[$];
    logic [7:0] reply[$];
    logic       miso_q[$];
    logic [7:0] host_rx[$];
    logic       busy_mid;

    always #5 clk = ~clk;

    spi_target_rx #(.WORD(WORD), .SYNC_STAGES(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_sck     (sck),
        .i_mosi    (mosi),
        .i_cs_n    (cs_n),
        .o_miso    (miso),
        .i_tx_data (tx_data),
        .o_tx_load (tx_load),
        .o_data    (data),
        .o_valid   (valid),
        .o_first   (first),
        .o_abort   (abort),
        .o_busy    (busy)
    );

    // Strobe monitor; after each reply load the next reply word is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                obs_data.push_back(data);
                obs_first.push_back(first);
            end
            if (abort) abort_cnt++;
            if (tx_load) begin
                load_cnt++;
                @(posedge clk);
                #1;
                tx_idx++;
                tx_data = (tx_idx < reply.size()) ? reply[tx_idx] : 8'h00;
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_data.delete();
        obs_first.delete();
        abort_cnt = 0;
        load_cnt  = 0;
        miso_q.delete();
        host_rx.delete();
    endtask

    // One SCK period in mode 0; MISO is captured at the rising edge.
    task automatic pulse(input logic v, input int half);
        mosi = v;
        #(half * 1ns);
        sck = 1'b1;
        miso_q.push_back(miso);
        #(half * 1ns);
        sck = 1'b0;
    endtask

    task automatic assemble_host();
        host_rx.delete();
        for (int k = 0; k < miso_q.size() / 8; k++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], miso_q[k*8+j]};
            host_rx.push_back(b);
        end
    endtask

    // Full host frame: nbits bits of tx_words, MSB first. With cs_with_last,
    // CS rises together with the final SCK rise.
    task automatic run_frame(input int nbits, input int half, input bit cs_with_last);
        clear_obs();
        tx_idx  = 0;
        tx_data = reply[0];
        cs_n = 1'b0;
        #100ns;
        busy_mid = busy;
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] w;
            w = tx_words[i/8];
            if (cs_with_last && i == nbits - 1) begin
                mosi = w[7-(i%8)];
                #(half * 1ns);
                sck  = 1'b1;
                cs_n = 1'b1;
                miso_q.push_back(miso);
                #(half * 1ns);
                sck = 1'b0;
            end else begin
                pulse(w[7-(i%8)], half);
            end
        end
        mosi = 1'b0;
        if (!cs_with_last) begin
            #100ns;
            cs_n = 1'b1;
        end
        #200ns;
        assemble_host();
        $display("frame bits=%0d half=%0dns valid=%0d abort=%0d loads=%0d",
                 nbits, half, obs_data.size(), abort_cnt, load_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++; if (miso !== 1'b0)    begin errors++; $display("FAIL rst_miso got %b want 0", miso); end
        checks++; if (data !== 8'h00)   begin errors++; $display("FAIL rst_data got %h want 00", data); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        checks++; if (first !== 1'b0)   begin errors++; $display("FAIL rst_first got %b want 0", first); end
        checks++; if (abort !== 1'b0)   begin errors++; $display("FAIL rst_abort got %b want 0", abort); end
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rst_tx_load got %b want 0", tx_load); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        rst_n = 1'b1;
        #100ns;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL post_rst_valid got %b want 0", valid); end
        $display("reset done");
    endtask

    task automatic test_single_word();
        tx_words = '{8'hA5};
        reply    = '{8'($urandom), 8'($urandom)};
        run_frame(8, 60, 1'b0);
        checks++; if (obs_data.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", obs_data.size()); end
        checks++; if (data !== 8'hA5)        begin errors++; $display("FAIL single_data got %h want a5", data); end
        checks++; if (obs_first.size() == 0 || obs_first[0] !== 1'b1) begin errors++; $display("FAIL single_first got %0d entries want first=1", obs_first.size()); end
        checks++; if (abort_cnt !== 0)       begin errors++; $display("FAIL single_abort got %0d want 0", abort_cnt); end
        checks++; if (busy_mid !== 1'b1)     begin errors++; $display("FAIL single_busy_mid got %b want 1", busy_mid); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
        checks++; if (host_rx.size() == 0 || host_rx[0] !== reply[0]) begin errors++; $display("FAIL single_miso got %h want %h", (host_rx.size() > 0) ? host_rx[0] : 8'hxx, reply[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_w[3];
        exp_w = '{8'h12, 8'h34, 8'h56};
        tx_words = '{8'h12, 8'h34, 8'h56};
        reply    = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(24, 60, 1'b0);
        checks++; if (obs_data.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", obs_data.size()); end
        for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            logic       f;
            d = (k < obs_data.size()) ? obs_data[k] : 8'hxx;
            f = (k < obs_first.size()) ? obs_first[k] : 1'bx;
            checks++; if (d !== exp_w[k]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", k, d, exp_w[k]); end
            checks++; if (f !== (k == 0)) begin errors++; $display("FAIL b2b_first%0d got %b want %b", k, f, (k == 0)); end
        end
        checks++; if (data !== 8'h56)  begin errors++; $display("FAIL b2b_hold got %h want 56", data); end
        checks++; if (abort_cnt !== 0) begin errors++; $display("FAIL b2b_abort got %0d want 0", abort_cnt); end
    endtask

    task automatic test_tx_reply();
        tx_words = '{8'($urandom), 8'($urandom)};
        reply    = '{8'hC3, 8'h3C, 8'h00};
        run_frame(16, 60, 1'b0);
        checks++; if (host_rx.size() < 2 || host_rx[0] !== 8'hC3) begin errors++; $display("FAIL reply_w0 got %h want c3", (host_rx.size() > 0) ? host_rx[0] : 8'hxx); end
        checks++; if (host_rx.size() < 2 || host_rx[1] !== 8'h3C) begin errors++; $display("FAIL reply_w1 got %h want 3c", (host_rx.size() > 1) ? host_rx[1] : 8'hxx); end
        checks++; if (load_cnt !== 3) begin errors++; $display("FAIL reply_loads got %0d want 3", load_cnt); end
        checks++; if (data !== tx_words[1]) begin errors++; $display("FAIL reply_rxdata got %h want %h", data, tx_words[1]); end
    endtask

    task automatic test_abort();
        logic [7:0] prev;
        prev = data;
        tx_words = '{8'b1011_0000};
        reply    = '{8'h00, 8'h00};
        run_frame(5, 60, 1'b0);
        checks++; if (abort_cnt !== 1)       begin errors++; $display("FAIL abort_count got %0d want 1", abort_cnt); end
        checks++; if (obs_data.size() !== 0) begin errors++; $display("FAIL abort_valid got %0d want 0", obs_data.size()); end
        checks++; if (data !== prev)         begin errors++; $display("FAIL abort_hold got %h want %h", data, prev); end
        tx_words = '{8'hFF};
        run_frame(8, 60, 1'b0);
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL abort_next_data got %h want ff", data); end
        checks++; if (obs_first.size() != 1 || obs_first[0] !== 1'b1) begin errors++; $display("FAIL abort_next_first got %0d entries want one with first=1", obs_first.size()); end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        reply    = '{8'hFF, 8'hFF};
        tx_idx   = 0;
        tx_data  = 8'hFF;
        cs_n = 1'b0;
        #100ns;
        for (int i = 0; i < 3; i++) pulse(1'b1, 60);
        rst_n = 1'b0;
        #50ns;
        rst_n = 1'b1;
        #50ns;
        clear_obs();
        for (int i = 0; i < 8; i++) pulse(1'b1, 60);
        #100ns;
        checks++; if (obs_data.size() !== 0) begin errors++; $display("FAIL midrst_valid got %0d want 0", obs_data.size()); end
        checks++; if (load_cnt !== 0)        begin errors++; $display("FAIL midrst_loads got %0d want 0", load_cnt); end
        checks++; if (data !== 8'h00)        begin errors++; $display("FAIL midrst_data got %h want 00", data); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (miso_q.sum() with (int'(item)) !== 0) begin errors++; $display("FAIL midrst_miso got %0d ones want 0", miso_q.sum() with (int'(item))); end
        cs_n = 1'b1;
        #200ns;
        checks++; if (abort_cnt !== 0)       begin errors++; $display("FAIL midrst_abort got %0d want 0", abort_cnt); end
        $display("midframe reset frame ignored");
        tx_words = '{8'h81};
        reply    = '{8'h00, 8'h00};
        run_frame(8, 60, 1'b0);
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL midrst_next_data got %h want 81", data); end
        checks++; if (obs_first.size() != 1 || obs_first[0] !== 1'b1) begin errors++; $display("FAIL midrst_next_first got %0d entries want one with first=1", obs_first.size()); end
    endtask

    task automatic test_idle_sck();
        clear_obs();
        cs_n = 1'b1;
        for (int i = 0; i < 8; i++) pulse(1'b1, 60);
        #200ns;
        checks++; if (obs_data.size() !== 0) begin errors++; $display("FAIL idle_valid got %0d want 0", obs_data.size()); end
        checks++; if (miso_q.sum() with (int'(item)) !== 0) begin errors++; $display("FAIL idle_miso got %0d ones want 0", miso_q.sum() with (int'(item))); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        $display("idle sck pulses=8");
        // A misaligned bit counter would corrupt this word.
        tx_words = '{8'h5A};
        reply    = '{8'h00, 8'h00};
        run_frame(8, 60, 1'b0);
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL idle_next_data got %h want 5a", data); end
        checks++; if (obs_data.size() !== 1) begin errors++; $display("FAIL idle_next_count got %0d want 1", obs_data.size()); end
    endtask

    task automatic test_simultaneous();
        tx_words = '{8'h6D};
        reply    = '{8'h00, 8'h00};
        run_frame(8, 60, 1'b1);
        checks++; if (obs_data.size() !== 1) begin errors++; $display("FAIL simul_count got %0d want 1", obs_data.size()); end
        checks++; if (data !== 8'h6D)        begin errors++; $display("FAIL simul_data got %h want 6d", data); end
        checks++; if (abort_cnt !== 0)       begin errors++; $display("FAIL simul_abort got %0d want 0", abort_cnt); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL simul_busy got %b want 0", busy); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int nw, extra, nbits, half, nfull;
            nw    = $urandom_range(0, 4);
            extra = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            nbits = nw * 8 + extra;
            if (nbits == 0) nbits = 8;
            nfull = nbits / 8;
            half  = 10 * $urandom_range(4, 8);
            tx_words.delete();
            reply.delete();
            for (int k = 0; k <= nfull; k++) tx_words.push_back(8'($urandom));
            for (int k = 0; k <= nfull + 1; k++) reply.push_back(8'($urandom));
            run_frame(nbits, half, 1'b0);
            checks++; if (obs_data.size() !== nfull) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, obs_data.size(), nfull); end
            for (int k = 0; k < nfull; k++) begin
                logic [7:0] d;
                logic       f;
                d = (k < obs_data.size()) ? obs_data[k] : 8'hxx;
                f = (k < obs_first.size()) ? obs_first[k] : 1'bx;
                checks++; if (d !== tx_words[k]) begin errors++; $display("FAIL rnd%0d_data%0d got %h want %h", t, k, d, tx_words[k]); end
                checks++; if (f !== (k == 0))    begin errors++; $display("FAIL rnd%0d_first%0d got %b want %b", t, k, f, (k == 0)); end
            end
            for (int i = 0; i < nbits; i++) begin
                logic [7:0] r;
                r = reply[i/8];
                checks++; if (miso_q[i] !== r[7-(i%8)]) begin errors++; $display("FAIL rnd%0d_miso_bit%0d got %b want %b", t, i, miso_q[i], r[7-(i%8)]); end
            end
            checks++; if (abort_cnt !== ((extra != 0) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_abort got %0d want %0d", t, abort_cnt, (extra != 0) ? 1 : 0); end
            checks++; if (load_cnt !== nfull + 1) begin errors++; $display("FAIL rnd%0d_loads got %0d want %0d", t, load_cnt, nfull + 1); end
        end
    endtask

    initial begin
        @(posedge clk);
        #2;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_tx_reply();
        test_abort();
        test_reset_midframe();
        test_idle_sck();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_target_rx.md
Name: spi_target_rx

Overview:
- FPGA-side SPI target (mode 0, MSB first) that receives the SPI host stream.
- Oversamples SCK/MOSI/CS_N in the system clock domain and deserializes WORD-bit words.
- Emits one-cycle valid strobes to the downstream command/pixel decoder.
- Shifts a per-word reply out on MISO.
- Sits directly downstream of the SPI host pins and upstream of the frame-buffer write logic.

Parameters:
- WORD, 8, bits per SPI word (legal range 2..32).
- SYNC_STAGES, 2, synchronizer flops on i_sck, i_mosi and i_cs_n (legal range 2..3).

Ports:
- i_clk  input  1  system clock; must run at ≥ 8× SCK.
- i_rst_n  input  1  synchronous, active-low reset.
- i_sck  input  1  SPI clock from the host, asynchronous to i_clk.
- i_mosi  input  1  SPI data from the host.
- i_cs_n  input  1  active-low chip select.
- o_miso  output  1  SPI data to the host.
- i_tx_data  input  WORD  reply word; sampled when o_tx_load=1.
- o_tx_load  output  1  1-cycle strobe; i_tx_data is captured into the TX shifter this cycle.
- o_data  output  WORD  last received word; held until the next o_valid.
- o_valid  output  1  1-cycle strobe: o_data holds a new complete word.
- o_first  output  1  qualifies o_valid: this is the first word since CS assertion.
- o_abort  output  1  1-cycle strobe: CS deasserted with a partial word (1..WORD-1 bits) pending.
- o_busy  output  1  1 while the synchronized CS is asserted.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State IDLE; bit_cnt=0; shift registers=0.
  - o_miso=0, o_data=0, o_valid=0, o_first=0, o_abort=0, o_tx_load=0, o_busy=0.
  - Synchronizer flops preset: sck=0, mosi=0, cs_n=1.
- Synchronization and edges:
  - i_sck, i_mosi and i_cs_n each pass through SYNC_STAGES flops on identical paths, so MOSI stays aligned with SCK.
  - One extra flop per signal provides edge detection: sck_rise, sck_fall, cs_fall, cs_rise.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on cs_fall. In that cycle: bit_cnt=0, first_flag=1, o_tx_load=1, TX shifter <= i_tx_data, o_busy=1.
  - ACTIVE -> IDLE on cs_rise. If bit_cnt≠0, pulse o_abort for 1 cycle and discard the partial word. o_busy=0. o_data is unchanged.
  - SCK edges are ignored in IDLE.
- Receive (ACTIVE, on sck_rise):
  - rx_shift <= {rx_shift[WORD-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches WORD-1 -> WORD: the next cycle has o_data=completed word, o_valid=1, o_first=first_flag.
  - Also on that rise: first_flag clears, bit_cnt wraps to 0, o_tx_load=1, and the TX shifter reloads from i_tx_data.
  - Latency from synchronized last rising edge to o_valid: 1 i_clk.
- Transmit:
  - o_miso = TX shifter MSB.
  - On sck_fall in ACTIVE with bit_cnt≠0: shift left, filling 0.
  - On sck_fall with bit_cnt=0 (just after a load): no shift, so the new MSB is already on the line before the next rising SCK edge.
  - In IDLE, o_miso=0.
- Simultaneous events:
  - cs_rise in the same cycle as the final sck_rise: the word completes (o_valid=1), then the block enters IDLE with no o_abort.
  - cs_rise and cs_fall cannot coincide.
  - Back-to-back CS frames with less than 2 i_clk between them are outside the supported range.
- Streaming: words arrive continuously while CS stays low. There is no back-pressure; the consumer must accept every o_valid.
- Reset mid-frame: all state is cleared. A frame still in progress is treated as new only after the synchronized CS deasserts and reasserts, because cs_fall requires a 1->0 transition.

Test Plan:
- CS low, send 0xA5 at SCK=8 MHz with i_clk=100 MHz, CS high -> exactly one o_valid with o_data=0xA5, o_first=1, no o_abort, o_busy 1->0.
- CS low, send 0x12,0x34,0x56 back-to-back -> three o_valid pulses with 0x12(first=1), 0x34(first=0), 0x56(first=0); o_data holds 0x56 afterwards.
- i_tx_data=0xC3 at CS fall, then 0x3C at the word-1 reload -> host receives 0xC3 then 0x3C; o_tx_load pulses at CS fall and at the word-1 completion.
- CS low, 5 SCK cycles of 0b10110, CS high -> o_abort=1 for 1 cycle, no o_valid, o_data keeps its previous value; next full frame sending 0xFF gives o_data=0xFF with first=1.
- Assert i_rst_n=0 after bit 3 of a frame, release with CS still low, finish 8 clocks -> no o_valid, all outputs 0; after CS high/low, 0x81 is received correctly.
- SCK toggling with CS high (8 pulses, MOSI=1) -> no o_valid, o_miso=0, bit_cnt remains 0.
